// File: rtl/serial_adder_unit.sv
// rtl/serial_adder_unit.sv - digit-serial adder/subtractor with Start/Busy/Done handshake
// One DIGIT-wide slice is reused for WIDTH/DIGIT cycles, LSB digit first.
module serial_adder_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]   w_slice;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_slice    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the slice's top bit; only meaningful on the last slice, where it is the carry into the MSB.
  assign w_cin_msb  = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_slice[DIGIT-1];
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      Carry    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_slice[DIGIT];
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Outputs change only here so they never show partial results.
            Sum      <= w_acc_next;
            Carry    <= w_slice[DIGIT];
            Overflow <= w_cin_msb ^ w_slice[DIGIT];
            Busy     <= 1'b0;
            Done     <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
